mp_add_seq: RTL and testbench



---
 rtl/mp_add_seq_if.sv | 31 +++
 rtl/mp_add_seq.sv | 111 +++++++++++
 tb/tb_mp_add_seq.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_add_seq_if.sv
// Issue/result handshake bundle for mp_add_seq.
//   in_valid/in_ready : request handshake carrying in_a, in_b, in_sub, in_cin
//   out_valid/out_ready : result handshake carrying out_sum, out_cout, out_ovf
// master = ALU issue side, slave = mp_add_seq.
interface mp_add_seq_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer. Feeds one shared combinational
// 16-bit adder one limb per cycle (LS limb first), chaining the carry
// through a register, and returns the W-bit result with carry-out and
// signed overflow.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : request/result handshakes (see mp_add_seq_if)
//   busy            : high while an operation is running or held in DONE
//   add_a, add_b    : limb operands to the shared adder (B pre-inverted for sub)
//   add_kin         : adder carry-in, 2'b00 = 0, 2'b11 = 1
//   add_sum         : adder result, bit 16 is the limb carry-out
module mp_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    mp_add_seq_if.slave bus,
    output logic        busy,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic [1:0]  add_kin,
    input  logic [16:0] add_sum
);
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WORDS-1:0][15:0] r_a;
    logic [WORDS-1:0][15:0] r_beff;
    logic [WORDS-1:0][15:0] r_sum;
    logic [KW-1:0]          r_k;
    logic                   r_carry;
    logic                   r_cout;
    logic                   r_ovf;

    // Sign of A and of the effective B decide whether overflow is possible
    logic w_a_msb;
    logic w_b_msb;
    assign w_a_msb = r_a[WORDS-1][15];
    assign w_b_msb = r_beff[WORDS-1][15];

    // Sequencer: accept, walk the limbs, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_beff  <= '0;
            r_sum   <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        // Subtraction is A + ~B + 1; in_cin is ignored then
                        r_beff  <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        r_carry <= bus.in_sub | bus.in_cin;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_k] <= add_sum[15:0];
                    r_carry    <= add_sum[16];
                    if (r_k == K_LAST) begin
                        r_cout  <= add_sum[16];
                        r_ovf   <= (w_a_msb == w_b_msb) && (add_sum[15] != w_a_msb);
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shared adder operands are only live while walking the limbs
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_kin = 2'b00;
        if (r_state == S_RUN) begin
            add_a   = r_a[r_k];
            add_b   = r_beff[r_k];
            add_kin = r_carry ? 2'b11 : 2'b00;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign busy          = (r_state == S_RUN) || (r_state == S_DONE);

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq with a behavioural adder and a
// whole-word arithmetic reference model.
module tb_mp_add_seq;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 16 * WORDS;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [1:0]  add_kin;
    logic [16:0] add_sum;

    int n_cmp;
    int n_err;

    logic [1:0]  tr_kin [WORDS];
    logic [15:0] tr_a   [WORDS];
    logic [15:0] tr_b   [WORDS];

    mp_add_seq_if #(.WORDS(WORDS)) bus ();

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_kin (add_kin),
        .add_sum (add_sum)
    );

    // Shared combinational adder with kill/generate carry-in
    assign add_sum = 17'(add_a) + 17'(add_b) + 17'(add_kin == 2'b11);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[16*i +: 16] = 16'hFFFF;
                1:       v[16*i +: 16] = 16'h0000;
                default: v[16*i +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Reference: {ovf, cout, sum} from whole-word arithmetic
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub, input logic cin);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        if (sub) begin
            s  = a - b;
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            s    = full[W-1:0];
            co   = full[W];
            ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {ov, co, s};
    endfunction

    // Present an op at a negedge, let one posedge accept it, then scramble inputs
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = rnd_w();
        bus.in_b     = rnd_w();
        bus.in_sub   = 1'($urandom);
        bus.in_cin   = 1'($urandom);
    endtask

    // From the negedge after the accept edge, count edges until out_valid
    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            if (lat < WORDS) begin
                tr_kin[lat] = add_kin;
                tr_a[lat]   = add_a;
                tr_b[lat]   = add_b;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = {W{1'b1}};
        bus.in_b     = {W{1'b1}};
        repeat (3) @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, expected 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        end
        n_cmp++;
        if (bus.out_sum !== '0 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: sum=%h cout=%b ovf=%b, expected 0 0 0",
                     bus.out_sum, bus.out_cout, bus.out_ovf);
        end
        n_cmp++;
        if (add_a !== 16'h0 || add_b !== 16'h0 || add_kin !== 2'b00) begin
            n_err++;
            $display("FAIL reset_adder: a=%h b=%h kin=%b, expected 0 0 00", add_a, add_b, add_kin);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid_ignored: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] a [4];
        logic [W-1:0] b [4];
        logic         s [4];
        logic         c [4];
        logic [W+1:0] exp;
        int           lat;
        a[0] = {W{1'b1}};            b[0] = W'(1); s[0] = 1'b0; c[0] = 1'b0;
        a[1] = '0;                   b[1] = W'(1); s[1] = 1'b1; c[1] = 1'b0;
        a[2] = {1'b0, {(W-1){1'b1}}}; b[2] = W'(1); s[2] = 1'b0; c[2] = 1'b0;
        a[3] = '0;                   b[3] = '0;    s[3] = 1'b0; c[3] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp = ref_op(a[t], b[t], s[t], c[t]);
            issue(a[t], b[t], s[t], c[t]);
            wait_valid(lat);
            n_cmp++;
            if (lat != WORDS) begin
                n_err++;
                $display("FAIL dir%0d_latency: %0d edges, expected %0d", t, lat, WORDS);
            end
            n_cmp++;
            if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== exp) begin
                n_err++;
                $display("FAIL dir%0d_result: ovf=%b cout=%b sum=%h, expected ovf=%b cout=%b sum=%h",
                         t, bus.out_ovf, bus.out_cout, bus.out_sum, exp[W+1], exp[W], exp[W-1:0]);
            end
            if (t == 0) begin
                n_cmp++;
                if (tr_kin[0] !== 2'b00 || tr_kin[1] !== 2'b11 || tr_kin[2] !== 2'b11 ||
                    tr_kin[3] !== 2'b11 || tr_a[0] !== 16'hFFFF) begin
                    n_err++;
                    $display("FAIL dir0_kin_trace: kin=%b,%b,%b,%b a0=%h, expected 00,11,11,11 a0=ffff",
                             tr_kin[0], tr_kin[1], tr_kin[2], tr_kin[3], tr_a[0]);
                end
            end
            if (t == 1) begin
                n_cmp++;
                if (tr_b[0] !== 16'hFFFE || tr_kin[0] !== 2'b11) begin
                    n_err++;
                    $display("FAIL dir1_sub_limb0: add_b=%h kin=%b, expected fffe 11", tr_b[0], tr_kin[0]);
                end
            end
            handshake();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         c;
        logic [W+1:0] exp;
        int           lat;
        for (int t = 0; t < 24; t++) begin
            a   = rnd_w();
            b   = rnd_w();
            s   = 1'($urandom);
            c   = 1'($urandom);
            exp = ref_op(a, b, s, c);
            issue(a, b, s, c);
            wait_valid(lat);
            n_cmp++;
            if (lat != WORDS || {bus.out_ovf, bus.out_cout, bus.out_sum} !== exp) begin
                n_err++;
                $display("FAIL rand%0d: lat=%0d ovf=%b cout=%b sum=%h, expected lat=%0d ovf=%b cout=%b sum=%h (a=%h b=%h sub=%b cin=%b)",
                         t, lat, bus.out_ovf, bus.out_cout, bus.out_sum, WORDS,
                         exp[W+1], exp[W], exp[W-1:0], a, b, s, c);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+1:0] exp;
        int           lat;
        int           bad;
        a   = rnd_w();
        b   = rnd_w();
        exp = ref_op(a, b, 1'b0, 1'b1);
        issue(a, b, 1'b0, 1'b1);
        wait_valid(lat);
        bad = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_a = rnd_w();
            bus.in_b = rnd_w();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b1 ||
                {bus.out_ovf, bus.out_cout, bus.out_sum} !== exp)
                bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0 || lat != WORDS) begin
            n_err++;
            $display("FAIL backpressure_hold: %0d unstable cycles, lat=%0d, expected 0 and %0d", bad, lat, WORDS);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b, expected 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        end
        n_cmp++;
        if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== exp) begin
            n_err++;
            $display("FAIL result_kept: sum=%h cout=%b, expected sum=%h cout=%b",
                     bus.out_sum, bus.out_cout, exp[W-1:0], exp[W]);
        end
    endtask

    task automatic test_reset_mid();
        logic [W+1:0] exp;
        int           lat;
        int           seen;
        issue({W{1'b1}}, {W{1'b1}}, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
            add_kin !== 2'b00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b sum=%h kin=%b busy=%b, expected 1 0 0 00 0",
                     bus.in_ready, bus.out_valid, bus.out_sum, add_kin, busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_mid_no_valid: out_valid high %0d cycles, expected 0", seen);
        end
        exp = ref_op(W'(16'h1234), W'(1), 1'b0, 1'b0);
        issue(W'(16'h1234), W'(1), 1'b0, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat != WORDS || bus.out_sum !== exp[W-1:0] || bus.out_sum !== W'(16'h1235)) begin
            n_err++;
            $display("FAIL reset_mid_recover: lat=%0d sum=%h, expected lat=%0d sum=%h", lat, bus.out_sum, WORDS, exp[W-1:0]);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        logic [W+1:0] e1;
        logic [W+1:0] e2;
        logic [W+1:0] r1;
        int           lat;
        a1 = rnd_w(); b1 = rnd_w(); a2 = rnd_w(); b2 = rnd_w();
        e1 = ref_op(a1, b1, 1'b1, 1'b0);
        e2 = ref_op(a2, b2, 1'b0, 1'b1);
        bus.in_a = a1; bus.in_b = b1; bus.in_sub = 1'b1; bus.in_cin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_a = a2; bus.in_b = b2; bus.in_sub = 1'b0; bus.in_cin = 1'b1;
        bus.out_ready = 1'b1;
        wait_valid(lat);
        r1 = {bus.out_ovf, bus.out_cout, bus.out_sum};
        n_cmp++;
        if (lat != WORDS || r1 !== e1) begin
            n_err++;
            $display("FAIL b2b_first: lat=%0d result=%h, expected lat=%0d result=%h", lat, r1, WORDS, e1);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_gap: in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_accept: busy=%b in_ready=%b, expected 1 0", busy, bus.in_ready);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat != WORDS || {bus.out_ovf, bus.out_cout, bus.out_sum} !== e2) begin
            n_err++;
            $display("FAIL b2b_second: lat=%0d result=%h, expected lat=%0d result=%h",
                     lat, {bus.out_ovf, bus.out_cout, bus.out_sum}, WORDS, e2);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
